// File: rtl/gpio_shiftout.sv
// gpio_shiftout: shifts each new data_in word MSB first onto a 74HC595-style chain, then strobes latch.
// Optional macro GPIO_SHIFTOUT_OE_EN keeps oe_n high until the first frame has been latched.
module gpio_shiftout #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             oe_n,
    output logic             busy,
    output logic             frame_done
);
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic             force_tx;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic             div_end;

    assign div_end = div_cnt == DW'(CLK_DIV - 1);

`ifdef GPIO_SHIFTOUT_OE_EN
    logic oe_q;
    assign oe_n = oe_q;
`else
    assign oe_n = 1'b0;
`endif

    // Outputs are registered and set on each state transition so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            force_tx   <= 1'b1;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            sclk       <= 1'b0;
            sdata      <= 1'b0;
            latch      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef GPIO_SHIFTOUT_OE_EN
            oe_q       <= 1'b1;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (force_tx || data_in != shadow) begin
                        shadow  <= data_in;
                        bit_cnt <= BW'(WIDTH - 1);
                        div_cnt <= '0;
                        busy    <= 1'b1;
                        sdata   <= data_in[WIDTH-1];
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (bit_cnt == '0) begin
                            sdata <= 1'b0;
                            latch <= 1'b1;
                            state <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            sdata   <= shadow[bit_cnt - 1'b1];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (div_end) begin
                        div_cnt    <= '0;
                        latch      <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        force_tx   <= 1'b0;
`ifdef GPIO_SHIFTOUT_OE_EN
                        oe_q       <= 1'b0;
`endif
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_shiftout.sv
// tb_gpio_shiftout: directed checks of frame contents, timing, coalescing, reset and a fast-divider instance.
module tb_gpio_shiftout;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d;
    logic [7:0]  f_d;
    logic        sclk, sdata, latch, oe_n, busy, frame_done;
    logic        f_sclk, f_sdata, f_latch, f_oe_n, f_busy, f_frame_done;
    int          vectors = 0;
    int          miscompares = 0;

`ifdef GPIO_SHIFTOUT_OE_EN
    localparam bit OE_EN = 1'b1;
`else
    localparam bit OE_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    gpio_shiftout dut (
        .clk(clk), .reset(reset), .data_in(d),
        .sclk(sclk), .sdata(sdata), .latch(latch), .oe_n(oe_n),
        .busy(busy), .frame_done(frame_done)
    );

    gpio_shiftout #(.WIDTH(8), .CLK_DIV(1)) dut_f (
        .clk(clk), .reset(reset), .data_in(f_d),
        .sclk(f_sclk), .sdata(f_sdata), .latch(f_latch), .oe_n(f_oe_n),
        .busy(f_busy), .frame_done(f_frame_done)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] exp_word;
        int          exp_len;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observes one frame at negedges; c1/c2 are busy-cycle indices at which d is changed mid-frame.
    task automatic capture(input bit sel, input int c1, input logic [31:0] v1,
                           input int c2, input logic [31:0] v2,
                           output logic [31:0] word, output int wait_cyc, output int len,
                           output int rises, output int toggles, output int lat,
                           output bit fd_ok, output bit oe_hi, output bit oe_end);
        logic ps, s;
        bit   b;
        word = '0; wait_cyc = 0; len = 0; rises = 0; toggles = 0; lat = 0;
        fd_ok = 1'b1; oe_hi = 1'b0; oe_end = 1'b1; ps = 1'b0; b = 1'b0;
        while (!b && wait_cyc < 2000) begin
            @(negedge clk);
            wait_cyc++;
            b = sel ? f_busy : busy;
        end
        while (b && len < 5000) begin
            s = sel ? f_sclk : sclk;
            len++;
            if (s && !ps) begin
                word = {word[30:0], sel ? f_sdata : sdata};
                rises++;
            end
            if (s != ps) toggles++;
            if (sel ? f_latch : latch) lat++;
            if (sel ? f_frame_done : frame_done) fd_ok = 1'b0;
            if (sel ? f_oe_n : oe_n) oe_hi = 1'b1;
            if (len == c1) d = v1;
            if (len == c2) d = v2;
            ps = s;
            @(negedge clk);
            b = sel ? f_busy : busy;
        end
        if (!(sel ? f_frame_done : frame_done) || (sel ? f_latch : latch) || (sel ? f_sclk : sclk))
            fd_ok = 1'b0;
        oe_end = sel ? f_oe_n : oe_n;
    endtask

    task automatic run(input string nm, input bit sel, input logic [31:0] ew, input int el,
                       input int er, input int elat, input bit eoe,
                       input int c1, input logic [31:0] v1, input int c2, input logic [31:0] v2);
        logic [31:0] w;
        int          wc, ln, r, tg, lt;
        bit          fo, oh, oe;
        capture(sel, c1, v1, c2, v2, w, wc, ln, r, tg, lt, fo, oh, oe);
        chk({nm, "_word"}, w, ew);
        chk({nm, "_latency"}, wc, 1);
        chk({nm, "_len"}, ln, el);
        chk({nm, "_rises"}, r, er);
        chk({nm, "_toggles"}, tg, 2 * er);
        chk({nm, "_latch_cycles"}, lt, elat);
        chk({nm, "_frame_done"}, {31'b0, fo}, 1);
        chk({nm, "_oe_n_during"}, {31'b0, oh}, {31'b0, eoe});
        chk({nm, "_oe_n_end"}, {31'b0, oe}, 0);
    endtask

    initial begin
        bit   quiet;
        int   n, k;
        logic ps;
        tbl[0] = '{32'hA5A5_0F0F, 32'hA5A5_0F0F, 260};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 260};
        tbl[2] = '{32'h0000_0001, 32'h0000_0001, 260};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 260};
        tbl[4] = '{32'h1234_5678, 32'h1234_5678, 260};

        reset = 1'b1; d = '0; f_d = '0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", {31'b0, sclk}, 0);
        chk("rst_sdata", {31'b0, sdata}, 0);
        chk("rst_latch", {31'b0, latch}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_frame_done", {31'b0, frame_done}, 0);
        chk("rst_oe_n", {31'b0, oe_n}, {31'b0, OE_EN});
        chk("rst_f_busy", {31'b0, f_busy}, 0);
        reset = 1'b0;
        run("pwr", 0, 32'h0, 260, 32, 4, OE_EN, -1, 0, -1, 0);

        for (int i = 0; i < 5; i++) begin
            d = tbl[i].data;
            run($sformatf("vec%0d", i), 0, tbl[i].exp_word, tbl[i].exp_len, 32, 4, 1'b0, -1, 0, -1, 0);
        end

        d = 32'h0F0F_0F0F;
        run("coal_cur", 0, 32'h0F0F_0F0F, 260, 32, 4, 1'b0, 50, 32'h1111_1111, 150, 32'h2222_2222);
        run("coal_next", 0, 32'h2222_2222, 260, 32, 4, 1'b0, -1, 0, -1, 0);

        quiet = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (sclk || latch || busy) quiet = 1'b0;
        end
        chk("idle_quiet", {31'b0, quiet}, 1);

        d = 32'h3C3C_3C3C;
        n = 0; k = 0; ps = 1'b0;
        while (n < 22 && k < 3000) begin
            @(negedge clk);
            k++;
            if (sclk && !ps) n++;
            ps = sclk;
        end
        chk("rst_mid_reached_bit10", n, 22);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_sclk", {31'b0, sclk}, 0);
        chk("rst_mid_sdata", {31'b0, sdata}, 0);
        chk("rst_mid_latch", {31'b0, latch}, 0);
        chk("rst_mid_frame_done", {31'b0, frame_done}, 0);
        chk("rst_mid_oe_n", {31'b0, oe_n}, {31'b0, OE_EN});
        @(negedge clk);
        reset = 1'b0;
        run("rst_frame", 0, 32'h3C3C_3C3C, 260, 32, 4, OE_EN, -1, 0, -1, 0);

        repeat (30) @(negedge clk);
        f_d = 8'h81;
        run("fast", 1, 32'h81, 17, 8, 1, 1'b0, -1, 0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gpio_shiftout.md
# gpio_shiftout

Serialises the 32-bit GPIO output word onto an external 74HC595-style shift-register chain. Sits directly downstream of the memory-mapped GPIO register and consumes its `gpio_out` bus. It watches the word for changes and shifts each new value out MSB first on `sclk`/`sdata`, then pulses `latch`. Software writes the GPIO register as usual, and the physical pins follow after one frame time.

## Interface
- `WIDTH`, default 32: bits per frame, equal to the width of `data_in`; must be ≥ 1.
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period and cycles of `latch` high; must be ≥ 1.
- `clk` input, 1 bit: system clock; all logic on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `data_in` input, WIDTH bits: parallel word, connected to `gpio_out`.
- `sclk` output, 1 bit: serial shift clock; external chain samples on the rising edge.
- `sdata` output, 1 bit: serial data, MSB first.
- `latch` output, 1 bit: storage-register strobe (RCLK).
- `oe_n` output, 1 bit: external output enable, active-low (see Configuration).
- `busy` output, 1 bit: high while a frame is in progress.
- `frame_done` output, 1 bit: one-cycle pulse when `latch` deasserts.

## Operation
- Internal state:
  - `shadow` (WIDTH bits): last word captured for transmission.
  - `force`: set by reset, so the first frame is sent unconditionally.
  - `bit_cnt`: current bit index.
  - `div_cnt`: counts 0..CLK_DIV-1.
- State machine: IDLE → SHIFT_LO → SHIFT_HI → (SHIFT_LO … | LATCH) → IDLE.
- IDLE:
  - `busy`=0, `sclk`=0, `latch`=0, `sdata`=0.
  - Trigger when `force` is set or `data_in != shadow`.
  - On trigger: `shadow` ← `data_in`, `bit_cnt` ← WIDTH-1, `div_cnt` ← 0, `busy` ← 1, go to SHIFT_LO.
- SHIFT_LO:
  - `sclk`=0, `sdata`=`shadow[bit_cnt]`, held stable for CLK_DIV cycles.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - `sclk`=1, `sdata` unchanged, for CLK_DIV cycles.
  - At the end: if `bit_cnt`==0 go to LATCH; otherwise decrement `bit_cnt` and go to SHIFT_LO.
- LATCH:
  - `sclk`=0, `sdata`=0, `latch`=1 for CLK_DIV cycles.
  - On exit: `force` ← 0, `frame_done` pulses, `busy` ← 0, go to IDLE.
- Changes to `data_in` while busy:
  - Ignored; `shadow` stays frozen for the whole frame.
  - IDLE re-compares on its first cycle, so multiple changes during a frame coalesce into one follow-up frame carrying the latest value.
- `data_in` is a synchronous internal signal; no synchroniser is required.

## Timing
- Values after reset, registered, from the first cycle after `reset` is sampled high:
  - `sclk`=0, `sdata`=0, `latch`=0, `busy`=0, `frame_done`=0.
  - `oe_n`=1 with the macro defined, 0 without.
  - `shadow`=0, `force`=1.
- Reset mid-frame: all of the above take effect immediately, the partial frame is abandoned, and a forced frame starts once reset is released.
- Trigger to first `sdata` bit: `busy` and the MSB appear on the cycle after the trigger cycle (1-cycle latency).
- Frame length is 2·CLK_DIV·WIDTH + CLK_DIV cycles of `busy`=1 (260 at the defaults).
- `sclk` rising edges per frame: exactly WIDTH. Each `sdata` bit is stable CLK_DIV cycles before and CLK_DIV cycles after its rising edge.
- `frame_done` asserts on the cycle `busy` falls.
- Back-to-back frames: IDLE lasts at least 1 cycle between frames, so the next `busy` rises 1 cycle after `frame_done`.
- Counter widths: `$clog2(WIDTH)` and `$clog2(CLK_DIV)`, minimum 1 bit. Counters never wrap within a state.

## Configuration
- Macro: `GPIO_SHIFTOUT_OE_EN`.
- Defined:
  - `oe_n` resets to 1 and stays high until the end of the first completed LATCH.
  - It goes to 0 the same cycle `frame_done` pulses, and then stays 0 until the next reset.
  - This prevents garbage on the external pins before the first valid frame.
- Undefined:
  - `oe_n` is tied to 0 and no enable flop is built.
  - All other behaviour is identical.

## Test plan
- Power-up frame:
  - Stimulus: reset for 3 cycles, `data_in`=0x0000_0000.
  - Required: one forced frame of 32 `sclk` rises, all `sdata`=0, a 4-cycle `latch`, `busy` high for 260 cycles.
  - With the macro, `oe_n` falls exactly on `frame_done`.
- Data pattern:
  - Stimulus: `data_in`=0xA5A5_0F0F after the power-up frame.
  - Required: the bits sampled at `sclk` rises, in order, reconstruct 0xA5A5_0F0F MSB first. `busy` rises 1 cycle after the change.
- Coalescing:
  - Stimulus: during a frame, `data_in` changes to 0x1111_1111 and then 0x2222_2222.
  - Required: the current frame is unchanged. Exactly one follow-up frame carries 0x2222_2222; there is no frame with 0x1111_1111.
- Idle quiet:
  - Stimulus: `data_in` held constant for 1000 cycles after a frame.
  - Required: `sclk`, `latch` and `busy` stay 0 throughout.
- Reset mid-frame:
  - Stimulus: assert `reset` at bit 10 of a frame.
  - Required: outputs return to their reset values the next cycle, and a full forced frame of the current `data_in` follows release.
- Fast divider:
  - Stimulus: CLK_DIV=1, WIDTH=8, `data_in`=0x81.
  - Required: `sclk` toggles every cycle, frame length is 17 cycles, serial data reads 1000_0001.
